// File: rtl/demux_pkg.sv
// Shared lane count, slot width and slot type for the 1:4 beat collector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package demux_pkg;
    localparam int NUM_LANES = 4;
    localparam int SLOT_W    = 2;
    typedef logic [SLOT_W-1:0] slot_t;
endpackage

// File: rtl/demux_lane_decode.sv
// 2-to-4 one-hot lane write-enable decode, the inverse of the 4:1 slice mux select.
// Latency: combinational.
// Backpressure: none; all lanes stay low when en_i is low.
module demux_lane_decode
    import demux_pkg::*;
(
    input  slot_t                slot_i,
    input  logic                 en_i,
    output logic [NUM_LANES-1:0] lane_en_o
);

    always_comb begin
        lane_en_o = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            lane_en_o[k] = en_i && (slot_i == slot_t'(k));
        end
    end

endmodule

// File: rtl/demux_1to4_collect.sv
// Collects four WIDTH-bit beats into one 4*WIDTH word; DEMUX_PARITY_EN adds out_parity.
// Latency: out_valid rises the cycle after the 4th accepted beat.
// Backpressure: in_ready drops only when a completion would overwrite an unconsumed word.
module demux_1to4_collect
    import demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [NUM_LANES*WIDTH-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SLOT_W-1:0]          slot
`ifdef DEMUX_PARITY_EN
    ,
    output logic                       out_parity
`endif
);

    slot_t                       slot_q, slot_d;
    logic [WIDTH-1:0]            lane_q [NUM_LANES-1];
    logic [NUM_LANES*WIDTH-1:0]  out_data_q, out_data_d;
    logic                        out_valid_q, out_valid_d;
    logic [NUM_LANES-1:0]        lane_en;
    logic                        accept;
    logic                        wr_en;
    logic                        complete;

    // Lane 3 is never stored: the final beat goes straight into the output word.
    assign in_ready = !((slot_q == slot_t'(NUM_LANES-1)) && out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;
    assign wr_en    = accept && !flush;

    demux_lane_decode u_decode (
        .slot_i    (slot_q),
        .en_i      (wr_en),
        .lane_en_o (lane_en)
    );

    assign complete = lane_en[NUM_LANES-1];

    always_comb begin
        slot_d      = slot_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            slot_d = '0;
        end else if (wr_en) begin
            slot_d = slot_q + slot_t'(1);
        end
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        // A completion wins over a same-cycle consume: the new word replaces the old.
        if (complete) begin
            out_data_d  = {in_data, lane_q[2], lane_q[1], lane_q[0]};
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < NUM_LANES-1; k++) begin
                lane_q[k] <= '0;
            end
        end else begin
            slot_q      <= slot_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            for (int k = 0; k < NUM_LANES-1; k++) begin
                if (flush) begin
                    lane_q[k] <= '0;
                end else if (lane_en[k]) begin
                    lane_q[k] <= in_data;
                end
            end
        end
    end

`ifdef DEMUX_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (complete) begin
            parity_q <= ^{in_data, lane_q[2], lane_q[1], lane_q[0]};
        end
    end

    assign out_parity = parity_q;
`endif

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign slot      = slot_q;

endmodule

// File: doc/demux_1to4_collect.md
# demux_1to4_collect

Serial-to-parallel counterpart of the ALU 4:1 slice multiplexer. It accepts a stream of WIDTH-bit beats over a valid/ready handshake and steers each beat into one of four lanes using a 2-bit slot counter, which is the inverse of the mux select. After four beats it presents the assembled 4×WIDTH word on a registered, back-pressured output. It sits between the serial slice datapath and the parallel ALU operand registers.

## Interface
- WIDTH, 1: bits per beat and per lane.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset. Assertion takes effect immediately; release is synchronous to clk.
- flush  in  1  synchronous abort of the partially collected word.
- in_data  in  WIDTH  beat payload.
- in_valid  in  1  beat offered.
- in_ready  out  1  block can accept a beat this cycle.
- out_data  out  4*WIDTH  assembled word. Lane k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts the word.
- slot  out  2  index of the lane the next accepted beat will fill.
- out_parity  out  1  XOR of out_data. Present only with DEMUX_PARITY_EN.

## Operation
- A beat is accepted when in_valid && in_ready. It is written to lane[slot], and slot increments modulo 4.
- Lane write enables are the one-hot decode of slot; exactly one lane is written per accept.
- Completion is an accept with slot==3. On completion the word {in_data, lane2, lane1, lane0} loads into the output register, out_valid is set, and slot wraps to 0.
- The output register is separate from the lane registers. Collection of the next word proceeds while the current word awaits out_ready.
- in_ready = !(slot==3 && out_valid && !out_ready). The block stalls only when a completion would overwrite an unconsumed word.
- A completion and an out_ready handshake in the same cycle are legal. The new word replaces the old one and out_valid stays 1.
- out_valid clears on out_ready while out_valid is set, unless a completion occurs in the same cycle.
- flush:
  - Sets slot to 0 and clears lanes 0–2.
  - Has priority over any beat accepted that cycle; that beat is discarded.
  - Does not affect out_data, out_valid or out_parity.
  - in_ready is unaffected by flush.
- Reset values: slot=0, lanes=0, out_data=0, out_valid=0, out_parity=0. in_ready=1 whenever reset is asserted.
- rst_n asserted mid-word discards the partial word and any pending output word.

## Timing
- Latency: out_valid rises the cycle after the 4th accept.
- in_ready is combinational from out_valid, out_ready and slot. There is no combinational path from in_valid to in_ready.
- Throughput with in_valid=out_ready=1: one beat per cycle and one word every 4 cycles, with no bubbles.
- Worst-case stall: while slot==3 and the output is held, in_ready stays 0 until the cycle out_ready is asserted.
- out_data and out_parity are registered. They are stable while out_valid=1 and out_ready=0.

## Configuration
- DEMUX_PARITY_EN defined:
  - out_parity port exists.
  - It is registered with out_data on completion, equals ^out_data, and resets to 0.
- DEMUX_PARITY_EN undefined: port and parity logic are absent. All other behaviour is identical.

## Structure
- Package demux_pkg holds:
  - NUM_LANES=4
  - SLOT_W=2
  - typedef logic [SLOT_W-1:0] slot_t
- Sub-module demux_lane_decode: slot_t plus an enable input, producing a 4-bit one-hot lane write enable. It is the 2-to-4 decode matching the mux select.
- The top level holds the slot counter, the lane registers, the output register and the handshake logic.

## Test plan
- WIDTH=1, out_ready=1, beats 1,0,1,1 on consecutive cycles. Expect out_data=4'b1101 and out_valid=1 for one cycle, the cycle after the 4th beat. With the macro, out_parity=1.
- out_ready=0, send 8 beats (word A=4'hA, then B=4'h5 up to its 3rd beat). Expect in_ready=0 at slot==3 and out_data stable at 4'hA. Raise out_ready: A is consumed, the B completion is accepted that cycle, and out_data=4'h5 next cycle.
- Continuous in_valid/out_ready for 16 beats. Expect 4 words, in_ready always 1, and slot sequence 0,1,2,3 repeating.
- 2 beats (1,1), then flush together with a 3rd beat, then beats 0,0,0,1. Expect slot=0 after the flush and out_data=4'b1000, with no trace of the flushed beats.
- Reset asserted mid-word at slot=2 with out_valid=1. Expect immediately slot=0, out_valid=0, out_data=0, in_ready=1.
- WIDTH=4, beats 4'h1,4'h2,4'h3,4'h4. Expect out_data=16'h4321.
